// File: rtl/fabric_bitstream_guard.sv
// Bitstream framing guard: locks onto a sync word, validates the length header,
// forwards sync + payload and checks a CRC-32/MPEG-2 trailer over the payload.
module fabric_bitstream_guard #(
    parameter logic [31:0] SYNC_WORD      = 32'hFAB0_FAB1,
    parameter logic [31:0] MAX_WORDS      = 32'h0000_052E,
    parameter int unsigned TIMEOUT_CYCLES = 65536
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] data_i,
    input  logic        valid_i,
    output logic [31:0] data_o,
    output logic        valid_o,
    output logic        busy_o,
    output logic        commit_o,
    output logic        error_o,
    output logic [1:0]  error_code_o,
    output logic [31:0] word_count_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LEN     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_CHECK   = 2'd3
    } state_t;

    localparam logic [31:0] CRC_POLY  = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_INIT  = 32'hFFFF_FFFF;
    localparam logic [31:0] IDLE_LAST = 32'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] CODE_OK      = 2'd0;
    localparam logic [1:0] CODE_BAD_LEN = 2'd1;
    localparam logic [1:0] CODE_BAD_CRC = 2'd2;
    localparam logic [1:0] CODE_TIMEOUT = 2'd3;

    // One full 32-bit word through the CRC, MSB first (big-endian byte order).
    function automatic logic [31:0] crc32_word(input logic [31:0] crc_in,
                                               input logic [31:0] word);
        logic [31:0] c;
        c = crc_in;
        for (int i = 31; i >= 0; i--) begin
            if (c[31] ^ word[i]) begin
                c = {c[30:0], 1'b0} ^ CRC_POLY;
            end else begin
                c = {c[30:0], 1'b0};
            end
        end
        return c;
    endfunction

    state_t      state_q, state_d;
    logic [31:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic        busy_q, busy_d;
    logic        commit_q, commit_d;
    logic        error_q, error_d;
    logic [1:0]  code_q, code_d;
    logic [31:0] count_q, count_d;
    logic [31:0] crc_q, crc_d;
    logic [31:0] idle_q, idle_d;
    logic [31:0] len_q, len_d;
    logic        timeout_s;
    logic [31:0] count_inc_s;

    // Expiry only when no word arrives in the final idle cycle: the word wins.
    assign timeout_s   = (state_q != ST_IDLE) && !valid_i && (idle_q == IDLE_LAST);
    assign count_inc_s = count_q + 32'd1;

    // Next-state and registered-output computation.
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        commit_d = 1'b0;
        error_d  = 1'b0;
        code_d   = code_q;
        count_d  = count_q;
        crc_d    = crc_q;
        idle_d   = idle_q;
        len_d    = len_q;

        if (state_q == ST_IDLE) begin
            idle_d = 32'd0;
        end else if (valid_i) begin
            idle_d = 32'd0;
        end else begin
            idle_d = idle_q + 32'd1;
        end

        if (timeout_s) begin
            error_d = 1'b1;
            code_d  = CODE_TIMEOUT;
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (valid_i && (data_i == SYNC_WORD)) begin
                        data_d  = data_i;
                        valid_d = 1'b1;
                        count_d = 32'd0;
                        code_d  = CODE_OK;
                        crc_d   = CRC_INIT;
                        state_d = ST_LEN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_LEN: begin
                    if (valid_i) begin
                        len_d = data_i;
                        if ((data_i == 32'd0) || (data_i > MAX_WORDS)) begin
                            error_d = 1'b1;
                            code_d  = CODE_BAD_LEN;
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_PAYLOAD;
                        end
                    end else begin
                        state_d = ST_LEN;
                    end
                end
                ST_PAYLOAD: begin
                    // An embedded sync word is ordinary payload here.
                    if (valid_i) begin
                        data_d  = data_i;
                        valid_d = 1'b1;
                        crc_d   = crc32_word(crc_q, data_i);
                        count_d = count_inc_s;
                        if (count_inc_s == len_q) begin
                            state_d = ST_CHECK;
                        end else begin
                            state_d = ST_PAYLOAD;
                        end
                    end else begin
                        state_d = ST_PAYLOAD;
                    end
                end
                ST_CHECK: begin
                    if (valid_i) begin
                        if (data_i == crc_q) begin
                            commit_d = 1'b1;
                            code_d   = CODE_OK;
                        end else begin
                            error_d = 1'b1;
                            code_d  = CODE_BAD_CRC;
                        end
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_CHECK;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            data_q   <= 32'd0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            commit_q <= 1'b0;
            error_q  <= 1'b0;
            code_q   <= CODE_OK;
            count_q  <= 32'd0;
            crc_q    <= CRC_INIT;
            idle_q   <= 32'd0;
            len_q    <= 32'd0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            commit_q <= commit_d;
            error_q  <= error_d;
            code_q   <= code_d;
            count_q  <= count_d;
            crc_q    <= crc_d;
            idle_q   <= idle_d;
            len_q    <= len_d;
        end
    end

    assign data_o       = data_q;
    assign valid_o      = valid_q;
    assign busy_o       = busy_q;
    assign commit_o     = commit_q;
    assign error_o      = error_q;
    assign error_code_o = code_q;
    assign word_count_o = count_q;

endmodule

// File: doc/fabric_bitstream_guard.md
# fabric_bitstream_guard

Framing and integrity checker between the SPI bitstream sources (controller/receiver mux) and the fabric configuration engine. It consumes the 32-bit word stream with a valid strobe and locks onto a sync word. It validates a length header and forwards only the sync word and payload words downstream. It checks a CRC-32 trailer and reports commit/error, so the core can distinguish a good load from a corrupted or truncated one.

## Interface
- `SYNC_WORD`, default `32'hFAB0_FAB1`: frame start marker.
- `MAX_WORDS`, default `32'h52E`: largest legal payload length.
- `TIMEOUT_CYCLES`, default `65536`: idle cycles inside a frame before abort.
- `clk_i` input, 1 bit: clock.
- `rst_i` input, 1 bit: synchronous, active-high reset.
- `data_i` input, 32 bits: bitstream word from the SPI mux.
- `valid_i` input, 1 bit: `data_i` valid this cycle. No backpressure.
- `data_o` output, 32 bits: forwarded word to the configuration engine.
- `valid_o` output, 1 bit: `data_o` valid.
- `busy_o` output, 1 bit: a frame is in progress (state ≠ IDLE).
- `commit_o` output, 1 bit: one-cycle pulse when the CRC matches.
- `error_o` output, 1 bit: one-cycle pulse on any frame error.
- `error_code_o` output, 2 bits: sticky code of the last frame. 0 = ok, 1 = bad length, 2 = CRC mismatch, 3 = timeout.
- `word_count_o` output, 32 bits: payload words accepted in the current or last frame.

## Operation
- Frame format on `data_i`: `SYNC_WORD`, then a length word N, then N payload words, then a CRC trailer.
- The CRC is CRC-32/MPEG-2 over the payload only: poly `0x04C11DB7`, init `0xFFFFFFFF`, no reflection, no final XOR. Each word is processed MSB-first, i.e. as big-endian bytes. The datapath is fully unrolled at one word per cycle.
- **IDLE**
  - Words not equal to `SYNC_WORD` are dropped silently.
  - On `SYNC_WORD`: forward it, clear `word_count_o`, clear `error_code_o` to 0, init the CRC, go to LEN.
- **LEN**
  - Latch N. The length word is never forwarded.
  - If N == 0 or N > `MAX_WORDS`: pulse `error_o`, code = 1, go to IDLE.
  - Otherwise go to PAYLOAD.
- **PAYLOAD**
  - Forward each word, update the CRC, increment `word_count_o`.
  - After the Nth word, go to CHECK.
  - A word equal to `SYNC_WORD` in this state is payload, not a resync.
- **CHECK**
  - The trailer is not forwarded.
  - If the trailer equals the CRC: pulse `commit_o`, code = 0.
  - Otherwise: pulse `error_o`, code = 2.
  - Either way, go to IDLE.
- **Timeout**
  - In LEN, PAYLOAD or CHECK, an idle counter increments on cycles without `valid_i` and clears on `valid_i`.
  - When the counter reaches `TIMEOUT_CYCLES`: pulse `error_o`, code = 3, go to IDLE.
  - If `valid_i` arrives in the expiry cycle, the word wins and no timeout occurs.
- Downstream has no retraction. On an error the core must hold the fabric unconfigured or reload.

## Timing
- Reset values (hold while `rst_i` = 1, sampled at `clk_i`): state IDLE, `data_o` = 0, `valid_o` = 0, `busy_o` = 0, `commit_o` = 0, `error_o` = 0, `error_code_o` = 0, `word_count_o` = 0, CRC = `0xFFFFFFFF`, idle counter = 0.
- Reset mid-frame aborts the frame with no `error_o` pulse.
- Forwarding is fully registered with 1-cycle latency: `valid_i` at cycle t gives `valid_o` at t+1 with the same data. When nothing is forwarded, `data_o` holds its last value.
- Back-to-back valid words are sustained at 1 word per cycle.
- `commit_o` and `error_o` assert in the cycle after the trailer, length word or timeout-expiry edge. They are mutually exclusive and last exactly 1 cycle.
- `busy_o` rises the cycle after `SYNC_WORD` is accepted and falls in the same cycle that `commit_o` or `error_o` asserts.
- A `SYNC_WORD` may arrive in the cycle immediately after a trailer. It is accepted, and a new frame starts with no gap.
- The CRC compare uses the register value after the last payload word. The trailer does not update the CRC.
- `word_count_o` is 32 bits and saturation is impossible, since N ≤ `MAX_WORDS` is enforced.

## Test plan
- **Good frame:** `FAB0FAB1`, 3, `11111111`, `22222222`, `33333333`, then the correct CRC-32/MPEG-2 of those 12 bytes.
  - `valid_o` fires 4 times: the sync word, then the 3 payload words, each 1 cycle after its input.
  - `commit_o` pulses once; `error_code_o` = 0; `word_count_o` = 3.
- **Corrupted CRC:** same frame, trailer XOR 1.
  - `error_o` pulses; `error_code_o` = 2; 4 words are forwarded.
- **Bad length:** `FAB0FAB1`, then 0 (repeat the frame with length `MAX_WORDS`+1).
  - Only the sync word is forwarded; `error_code_o` = 1; `busy_o` drops; following payload words are dropped in IDLE.
- **Timeout:** `TIMEOUT_CYCLES` = 16, frame with length 2, send only 1 payload word, then idle.
  - `error_code_o` = 3 exactly 16 idle cycles later.
  - Variant with `valid_i` in the 16th idle cycle: no timeout.
- **Garbage and sync-in-payload:** 5 random non-sync words, then a length-2 frame whose first payload word equals `SYNC_WORD`.
  - The garbage is dropped; the embedded sync is treated as payload; `commit_o` pulses.
- **Reset mid-frame, back-to-back frames:**
  - Assert `rst_i` during PAYLOAD: all outputs are at reset values the next cycle, with no `error_o`.
  - Two good frames with zero gap: two `commit_o` pulses.
